// File: rtl/reorder_fifo_pkg.sv
// reorder_fifo_pkg: record layout shared by dispatch, commit and the reorder FIFO.
// Field offsets index into the packed record {pc, rd0, is_branch, is_su, is_csr, is_ecall, is_ebreak, is_mret}.
package reorder_fifo_pkg;
    localparam int RB          = 1;
    localparam int RD0_W       = 5 + RB;
    localparam int PC_W        = 64;
    localparam int FLAG_W      = 6;
    localparam int INFO_DW     = PC_W + RD0_W + FLAG_W;
    localparam int MRET_BIT    = 0;
    localparam int EBREAK_BIT  = 1;
    localparam int ECALL_BIT   = 2;
    localparam int CSR_BIT     = 3;
    localparam int SU_BIT      = 4;
    localparam int BRANCH_BIT  = 5;
    localparam int RD0_LSB     = FLAG_W;
    localparam int PC_LSB      = FLAG_W + RD0_W;
endpackage

// File: rtl/reorder_store.sv
// reorder_store: DEPTH x DW flop array with one write port and one asynchronous read port.
// Contents are deliberately not reset; the pointers alone define validity.
module reorder_store
    import reorder_fifo_pkg::*;
#(
    parameter int DW = INFO_DW,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/reorder_fifo.sv
// reorder_fifo: in-order reorder buffer between dispatch and commit; flush clears all in-flight records.
// Define REORDER_FIFO_STAT_EN to add the occupancy (cnt) and high-water-mark (hwm) outputs.
module reorder_fifo
    import reorder_fifo_pkg::*;
#(
    parameter int DW = INFO_DW,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          flush,
    input  logic          reOrder_fifo_push,
    input  logic [DW-1:0] dispat_info,
    output logic          reOrder_fifo_full,
    input  logic          reOrder_fifo_pop,
    output logic          reOrder_fifo_empty,
    output logic [DW-1:0] commit_fifo
`ifdef REORDER_FIFO_STAT_EN
    ,
    output logic [AW:0]   reOrder_fifo_cnt,
    output logic [AW:0]   reOrder_fifo_hwm
`endif
);
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push_ok, pop_ok;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign reOrder_fifo_empty = wr_ptr == rd_ptr;
    assign reOrder_fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = reOrder_fifo_push && !reOrder_fifo_full && !flush;
    assign pop_ok  = reOrder_fifo_pop && !reOrder_fifo_empty && !flush;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push_ok);
            rd_ptr <= rd_ptr + (AW+1)'(pop_ok);
        end
    end

    reorder_store #(.DW(DW), .AW(AW)) u_store (
        .CLK   (CLK),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (dispat_info),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (commit_fifo)
    );

`ifdef REORDER_FIFO_STAT_EN
    assign reOrder_fifo_cnt = wr_ptr - rd_ptr;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) reOrder_fifo_hwm <= '0;
        else if (reOrder_fifo_cnt > reOrder_fifo_hwm) reOrder_fifo_hwm <= reOrder_fifo_cnt;
    end
`endif

    a_push_full: assert property (@(posedge CLK) disable iff (!RSTn) !(reOrder_fifo_push && reOrder_fifo_full))
        else $warning("reorder_fifo: push while full was ignored");
    a_pop_empty: assert property (@(posedge CLK) disable iff (!RSTn) !(reOrder_fifo_pop && reOrder_fifo_empty))
        else $warning("reorder_fifo: pop while empty was ignored");
endmodule

// File: tb/tb_reorder_fifo.sv
// tb_reorder_fifo: scoreboard bench for reorder_fifo; statistics checks compile in with REORDER_FIFO_STAT_EN.
module tb_reorder_fifo;
    import reorder_fifo_pkg::*;
    localparam int DW = INFO_DW;
    localparam int AW = 4;
    localparam int DEPTH = 2**AW;

    logic          CLK = 0;
    logic          RSTn = 0;
    logic          flush = 0;
    logic          reOrder_fifo_push = 0;
    logic [DW-1:0] dispat_info = '0;
    logic          reOrder_fifo_full;
    logic          reOrder_fifo_pop = 0;
    logic          reOrder_fifo_empty;
    logic [DW-1:0] commit_fifo;
`ifdef REORDER_FIFO_STAT_EN
    logic [AW:0]   reOrder_fifo_cnt;
    logic [AW:0]   reOrder_fifo_hwm;
`endif

    reorder_fifo #(.DW(DW), .AW(AW)) dut (
        .CLK                (CLK),
        .RSTn               (RSTn),
        .flush              (flush),
        .reOrder_fifo_push  (reOrder_fifo_push),
        .dispat_info        (dispat_info),
        .reOrder_fifo_full  (reOrder_fifo_full),
        .reOrder_fifo_pop   (reOrder_fifo_pop),
        .reOrder_fifo_empty (reOrder_fifo_empty),
        .commit_fifo        (commit_fifo)
`ifdef REORDER_FIFO_STAT_EN
        ,
        .reOrder_fifo_cnt   (reOrder_fifo_cnt),
        .reOrder_fifo_hwm   (reOrder_fifo_hwm)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails = 0;
    logic [DW-1:0] q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [63:0] pc);
        logic [RD0_W-1:0]  rd = RD0_W'($urandom);
        logic [FLAG_W-1:0] fl = FLAG_W'($urandom);
        return {pc, rd, fl};
    endfunction

    // Drive one cycle, check flags and popped head against the model, then update the model.
    task automatic cycle(input logic push, input logic pop, input logic fl, input logic [DW-1:0] rec);
        int n;
        @(negedge CLK);
        reOrder_fifo_push = push;
        reOrder_fifo_pop  = pop;
        flush             = fl;
        dispat_info       = rec;
        n = q.size();
        #1;
        check("empty", reOrder_fifo_empty, n == 0);
        check("full", reOrder_fifo_full, n == DEPTH);
`ifdef REORDER_FIFO_STAT_EN
        check("cnt", reOrder_fifo_cnt, n);
`endif
        if (pop && n > 0 && !fl) check("head", commit_fifo, q.pop_front());
        if (fl) q.delete();
        else if (push && n < DEPTH) q.push_back(rec);
        @(posedge CLK);
        #1;
        reOrder_fifo_push = 0;
        reOrder_fifo_pop  = 0;
        flush             = 0;
    endtask

    initial begin
        logic [DW-1:0] r;
        repeat (2) @(negedge CLK);
        RSTn = 1;

        // Async reset with 5 entries held
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, mk(64'h100 + 64'(i)));
        @(negedge CLK);
        RSTn = 0;
        #1;
        check("rst_empty", reOrder_fifo_empty, 1);
        check("rst_full", reOrder_fifo_full, 0);
`ifdef REORDER_FIFO_STAT_EN
        check("rst_cnt", reOrder_fifo_cnt, 0);
        check("rst_hwm", reOrder_fifo_hwm, 0);
`endif
        q.delete();
        @(negedge CLK);
        RSTn = 1;

        // Peak of 9 then flush; high-water mark survives the flush
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, mk(64'h200 + 64'(i)));
        cycle(0, 0, 0, '0);
        cycle(0, 0, 1, '0);
        cycle(0, 0, 0, '0);
`ifdef REORDER_FIFO_STAT_EN
        check("hwm_after_flush", reOrder_fifo_hwm, 9);
`endif

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, mk(64'h8000_0000 + 64'(4*i)));
        check("full_after_16", reOrder_fifo_full, 1);
        cycle(1, 0, 0, mk(64'hdead));
        for (int i = 0; i < DEPTH; i++) begin
            check("pc_order", commit_fifo[DW-1 -: 64], 64'h8000_0000 + 64'(4*i));
            cycle(0, 1, 0, '0);
        end
        check("empty_after_16", reOrder_fifo_empty, 1);

        // Wrap with 3 entries in flight
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, mk(64'h3000 + 64'(i)));
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, mk(64'h4000 + 64'(i)));
        while (q.size() > 0) cycle(0, 1, 0, '0);

        // Push and pop at full: push refused
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, mk(64'h5000 + 64'(i)));
        cycle(1, 1, 0, mk(64'hbad));
        check("full_pp_full", reOrder_fifo_full, 0);
`ifdef REORDER_FIFO_STAT_EN
        check("full_pp_cnt", reOrder_fifo_cnt, 15);
`endif
        while (q.size() > 0) cycle(0, 1, 0, '0);

        // Push and pop at empty: pop refused, head visible next cycle
        r = mk(64'h6000);
        cycle(1, 1, 0, r);
        check("empty_pp_head", commit_fifo, r);
        check("empty_pp_empty", reOrder_fifo_empty, 0);
`ifdef REORDER_FIFO_STAT_EN
        check("empty_pp_cnt", reOrder_fifo_cnt, 1);
`endif
        cycle(0, 1, 0, '0);

        // Flush with push and pop pending
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, mk(64'h7000 + 64'(i)));
        cycle(1, 1, 1, mk(64'h7fff));
        check("flush_empty", reOrder_fifo_empty, 1);
        check("flush_full", reOrder_fifo_full, 0);
`ifdef REORDER_FIFO_STAT_EN
        check("flush_cnt", reOrder_fifo_cnt, 0);
`endif
        r = mk(64'h1000);
        cycle(1, 0, 0, r);
        check("post_flush_head", commit_fifo, r);
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
